// File: rtl/reg_scoreboard.sv
// reg_scoreboard: RAW/WAW hazard tracker for the RV32I register file, plus registered read-address staging.
// Optional build macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback to a source register clears its hazard.
module reg_scoreboard #(
   parameter int MAX_PENDING = 4,
   parameter int CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       issue_rs1,
   input  logic [4:0]       issue_rs2,
   input  logic             issue_uses_rs1,
   input  logic             issue_uses_rs2,
   input  logic [4:0]       issue_rd,
   input  logic             issue_rd_we,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic             flush,
   output logic [4:0]       rf_rs1,
   output logic [4:0]       rf_rs2,
   output logic             rd_valid,
   output logic [4:0]       rd_tag,
   output logic [31:0]      busy_mask,
   output logic [CNT_W-1:0] pending_count,
   output logic             wb_err
);

   localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PENDING);

   logic [31:0]      busy_q, busy_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [4:0]       rf_rs1_q, rf_rs1_d;
   logic [4:0]       rf_rs2_q, rf_rs2_d;
   logic             s1_valid_q, s1_valid_d;
   logic [4:0]       s1_tag_q, s1_tag_d;
   logic             rd_valid_q, rd_valid_d;
   logic [4:0]       rd_tag_q, rd_tag_d;
   logic             wb_err_q, wb_err_d;

   logic [31:0] bypass_vec;
   logic [31:0] src_busy;
   logic [31:0] set_vec;
   logic [31:0] clr_vec;
   logic        hz_rs1, hz_rs2, waw, full;
   logic        wb_hit, wb_clr, wb_stray;
   logic        accept, set_en;

`ifdef SCOREBOARD_WB_BYPASS_EN
   // The write lands at the accept edge and the register file reads one edge later, so the read sees it.
   assign bypass_vec = wb_valid ? (32'd1 << wb_rd) : 32'd0;
`else
   assign bypass_vec = 32'd0;
`endif

   assign src_busy = busy_q & ~bypass_vec;

   assign hz_rs1 = issue_uses_rs1 && (issue_rs1 != 5'd0) && src_busy[issue_rs1];
   assign hz_rs2 = issue_uses_rs2 && (issue_rs2 != 5'd0) && src_busy[issue_rs2];
   assign waw    = issue_rd_we && (issue_rd != 5'd0) && busy_q[issue_rd];

   // busy_q[0] is always 0, so wb_hit is already false for x0.
   assign wb_hit   = wb_valid && busy_q[wb_rd];
   assign wb_clr   = wb_hit && !flush;
   assign wb_stray = wb_valid && (wb_rd != 5'd0) && !busy_q[wb_rd] && !flush;

   assign full = (count_q >= MAX_P) && !wb_hit;

   assign issue_ready = !rst && !flush && !hz_rs1 && !hz_rs2 && !waw && !full;
   assign accept      = issue_valid && issue_ready;
   assign set_en      = accept && issue_rd_we && (issue_rd != 5'd0);

   assign set_vec[0] = 1'b0;
   assign clr_vec[0] = 1'b0;
   for (genvar gi = 1; gi < 32; gi++) begin : g_busy_bit
      assign set_vec[gi] = set_en && (issue_rd == 5'(gi));
      assign clr_vec[gi] = wb_clr && (wb_rd == 5'(gi));
   end

   always_comb begin
      busy_d     = busy_q;
      count_d    = count_q;
      rf_rs1_d   = rf_rs1_q;
      rf_rs2_d   = rf_rs2_q;
      s1_valid_d = accept;
      s1_tag_d   = s1_tag_q;
      rd_valid_d = s1_valid_q;
      rd_tag_d   = s1_tag_q;
      wb_err_d   = wb_err_q | wb_stray;

      if (accept) begin
         rf_rs1_d = issue_uses_rs1 ? issue_rs1 : 5'd0;
         rf_rs2_d = issue_uses_rs2 ? issue_rs2 : 5'd0;
         s1_tag_d = issue_rd;
      end

      if (flush) begin
         busy_d     = 32'd0;
         count_d    = '0;
         s1_valid_d = 1'b0;
         rd_valid_d = 1'b0;
      end else begin
         // waw stalls any set that would target the register being cleared.
         busy_d  = (busy_q & ~clr_vec) | set_vec;
         count_d = count_q + CNT_W'(set_en) - CNT_W'(wb_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= 32'd0;
         count_q    <= '0;
         rf_rs1_q   <= 5'd0;
         rf_rs2_q   <= 5'd0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= 5'd0;
         rd_valid_q <= 1'b0;
         rd_tag_q   <= 5'd0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         count_q    <= count_d;
         rf_rs1_q   <= rf_rs1_d;
         rf_rs2_q   <= rf_rs2_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         rd_valid_q <= rd_valid_d;
         rd_tag_q   <= rd_tag_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign rf_rs1        = rf_rs1_q;
   assign rf_rs2        = rf_rs2_q;
   assign rd_valid      = rd_valid_q;
   assign rd_tag        = rd_tag_q;
   assign busy_mask     = busy_q;
   assign pending_count = count_q;
   assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_uses_rs1, issue_uses_rs2, issue_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [4:0]  rf_rs1, rf_rs2;
    logic        rd_valid;
    logic [4:0]  rd_tag;
    logic [31:0] busy_mask;
    logic [4:0]  pending_count;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    bit         m_busy [32];
    bit         m_err;
    bit         m_prev_acc;
    logic [4:0] m_last_rd;
    logic [4:0] m_rf1, m_rf2;
    bit         m_rd_valid;
    logic [4:0] m_rd_tag;

    reg_scoreboard #(.MAX_PENDING(MAXP), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rd_valid(rd_valid), .rd_tag(rd_tag),
        .busy_mask(busy_mask), .pending_count(pending_count), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int m_count();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] v = 32'd0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready();
        bit hz1, hz2, waw, full;
        hz1  = issue_uses_rs1 && issue_rs1 != 0 && m_busy[issue_rs1] && !(BYP && wb_valid && wb_rd == issue_rs1);
        hz2  = issue_uses_rs2 && issue_rs2 != 0 && m_busy[issue_rs2] && !(BYP && wb_valid && wb_rd == issue_rs2);
        waw  = issue_rd_we && issue_rd != 0 && m_busy[issue_rd];
        full = m_count() >= MAXP && !(wb_valid && wb_rd != 0 && m_busy[wb_rd]);
        return !rst && !flush && !hz1 && !hz2 && !waw && !full;
    endfunction

    task automatic tick();
        bit acc;
        acc = issue_valid && m_ready();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_err = 0; m_prev_acc = 0; m_last_rd = 0;
            m_rf1 = 0; m_rf2 = 0; m_rd_valid = 0; m_rd_tag = 0;
        end else begin
            m_rd_valid = m_prev_acc && !flush;
            m_rd_tag   = m_last_rd;
            if (acc) begin
                m_last_rd = issue_rd;
                m_rf1 = issue_uses_rs1 ? issue_rs1 : 5'd0;
                m_rf2 = issue_uses_rs2 ? issue_rs2 : 5'd0;
            end
            m_prev_acc = acc;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (wb_valid && wb_rd != 0) begin
                    if (m_busy[wb_rd]) m_busy[wb_rd] = 1'b0;
                    else m_err = 1'b1;
                end
                if (acc && issue_rd_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; issue_valid = 0; wb_valid = 0; wb_rd = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
        issue_rd = 0; issue_rd_we = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit we);
        issue_valid = 1; issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = rs2; issue_uses_rs2 = u2;
        issue_rd = rd; issue_rd_we = we;
    endtask

    task automatic clean();
        idle(); flush = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        issue(5'd1, 1, 5'd2, 1, 5'd3, 1);
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", issue_ready); end
        tick(); tick();
        idle(); #1;
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy_mask); end
        total++; if (pending_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", pending_count); end
        total++; if (rd_valid !== 1'b0 || rd_tag !== 5'd0) begin bad++; $display("FAIL reset_rd got=%b/%0d want=0/0", rd_valid, rd_tag); end
        total++; if (rf_rs1 !== 5'd0 || rf_rs2 !== 5'd0) begin bad++; $display("FAIL reset_rf got=%0d/%0d want=0/0", rf_rs1, rf_rs2); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", wb_err); end
        $display("test_reset checked");
    endtask

    task automatic test_basic_issue();
        idle(); issue(5'd1, 1, 5'd2, 1, 5'd3, 1); #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", issue_ready); end
        tick(); idle();
        total++; if (rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2) begin bad++; $display("FAIL basic_rf got=%0d/%0d want=1/2", rf_rs1, rf_rs2); end
        total++; if (busy_mask !== 32'h8 || pending_count !== 5'd1) begin
            bad++; $display("FAIL basic_busy got=%h/%0d want=8/1", busy_mask, pending_count);
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b1 || rd_tag !== 5'd3) begin bad++; $display("FAIL basic_rd got=%b/%0d want=1/3", rd_valid, rd_tag); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse got=%b want=0", rd_valid); end
        wb_valid = 1; wb_rd = 3; tick(); idle();
        total++; if (busy_mask !== 32'd0 || pending_count !== 5'd0) begin
            bad++; $display("FAIL basic_wb got=%h/%0d want=0/0", busy_mask, pending_count);
        end
        $display("test_basic_issue rs1=1 rs2=2 rd=3");
    endtask

    task automatic test_raw();
        clean();
        issue(5'd0, 0, 5'd0, 0, 5'd5, 1); tick(); idle();
        issue(5'd5, 1, 5'd0, 0, 5'd0, 0); #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%b want=0", issue_ready); end
        wb_valid = 1; wb_rd = 5; #1;
        total++; if (issue_ready !== BYP) begin bad++; $display("FAIL raw_wb_same_cycle got=%b want=%b", issue_ready, BYP); end
        tick();
        wb_valid = 0; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_after_wb got=%b want=1", issue_ready); end
        tick(); idle();
        total++; if (busy_mask[5] !== 1'b0) begin bad++; $display("FAIL raw_busy5 got=%b want=0", busy_mask[5]); end
        $display("test_raw rs1=5 bypass=%0d", BYP);
    endtask

    task automatic test_waw_x0();
        clean();
        issue(5'd0, 0, 5'd0, 0, 5'd7, 1); tick();
        #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b want=0", issue_ready); end
        tick();
        wb_valid = 1; wb_rd = 7; #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_no_bypass got=%b want=0", issue_ready); end
        tick(); wb_valid = 0; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_release got=%b want=1", issue_ready); end
        tick(); idle();
        total++; if (busy_mask !== 32'h80) begin bad++; $display("FAIL waw_busy got=%h want=80", busy_mask); end
        issue(5'd0, 1, 5'd0, 1, 5'd0, 1); #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", issue_ready); end
        tick(); idle();
        total++; if (busy_mask !== 32'h80 || pending_count !== 5'd1) begin
            bad++; $display("FAIL x0_busy got=%h/%0d want=80/1", busy_mask, pending_count);
        end
        $display("test_waw_x0 rd=7 then rd=0");
    endtask

    task automatic test_full();
        clean();
        for (int r = 1; r <= 4; r++) begin
            issue(5'd0, 0, 5'd0, 0, 5'(r), 1); tick();
        end
        idle();
        total++; if (pending_count !== 5'd4 || busy_mask !== 32'h1E) begin
            bad++; $display("FAIL full_fill got=%h/%0d want=1e/4", busy_mask, pending_count);
        end
        issue(5'd0, 0, 5'd0, 0, 5'd5, 1); #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_stall got=%b want=0", issue_ready); end
        wb_valid = 1; wb_rd = 2; #1;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_wb_frees got=%b want=1", issue_ready); end
        tick(); idle();
        total++; if (pending_count !== 5'd4 || busy_mask !== 32'h3A) begin
            bad++; $display("FAIL full_swap got=%h/%0d want=3a/4", busy_mask, pending_count);
        end
        $display("test_full max=%0d", MAXP);
    endtask

    task automatic test_flush();
        clean();
        for (int r = 1; r <= 3; r++) begin
            issue(5'd0, 0, 5'd0, 0, 5'(r), 1); tick();
        end
        flush = 1; issue(5'd0, 0, 5'd0, 0, 5'd4, 1); #1;
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", issue_ready); end
        tick(); idle();
        total++; if (busy_mask !== 32'd0 || pending_count !== 5'd0) begin
            bad++; $display("FAIL flush_busy got=%h/%0d want=0/0", busy_mask, pending_count);
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL flush_rd_valid got=%b want=0", rd_valid); end
        tick();
        total++; if (rd_valid !== 1'b0 || busy_mask !== 32'd0) begin
            bad++; $display("FAIL flush_no_accept got=%b/%h want=0/0", rd_valid, busy_mask);
        end
        $display("test_flush three busy");
    endtask

    task automatic test_wb_err();
        clean();
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", wb_err); end
        wb_valid = 1; wb_rd = 9; tick(); idle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", wb_err); end
        flush = 1; tick(); idle();
        total++; if (wb_err !== 1'b1) begin bad++; $display("FAIL err_flush got=%b want=1", wb_err); end
        rst = 1; tick(); idle();
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL err_rst got=%b want=0", wb_err); end
        tick();
        $display("test_wb_err wb_rd=9");
    endtask

    task automatic test_back_to_back();
        int w;
        clean();
        for (int n = 0; n < 400; n++) begin
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_rs1      = 5'($urandom_range(0, 7));
            issue_rs2      = 5'($urandom_range(0, 7));
            issue_uses_rs1 = 1'($urandom_range(0, 1));
            issue_uses_rs2 = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 7));
            issue_rd_we    = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 29) == 0);
            wb_valid       = !flush && ($urandom_range(0, 2) == 0);
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0)
                for (int t = 0; t < 8 && !m_busy[w]; t++) w = $urandom_range(1, 7);
            wb_rd = 5'(w);
            #1;
            total++; if (issue_ready !== m_ready()) begin
                bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", n, issue_ready, m_ready());
            end
            $display("cyc %0d valid=%b rd=%0d we=%b wb=%b/%0d flush=%b", n, issue_valid, issue_rd, issue_rd_we,
                     wb_valid, wb_rd, flush);
            tick();
            total++; if (busy_mask !== m_mask()) begin
                bad++; $display("FAIL rnd_busy cyc=%0d got=%h want=%h", n, busy_mask, m_mask());
            end
            total++; if (pending_count !== 5'(m_count())) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", n, pending_count, m_count());
            end
            total++; if (rd_valid !== m_rd_valid || rd_tag !== m_rd_tag) begin
                bad++; $display("FAIL rnd_rd cyc=%0d got=%b/%0d want=%b/%0d", n, rd_valid, rd_tag, m_rd_valid, m_rd_tag);
            end
            total++; if (rf_rs1 !== m_rf1 || rf_rs2 !== m_rf2) begin
                bad++; $display("FAIL rnd_rf cyc=%0d got=%0d/%0d want=%0d/%0d", n, rf_rs1, rf_rs2, m_rf1, m_rf2);
            end
            total++; if (wb_err !== m_err) begin
                bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", n, wb_err, m_err);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_raw();
        test_waw_x0();
        test_full();
        test_flush();
        test_wb_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side hazard controller for the RV32I register file: tracks which architectural registers have writes in flight and stalls dependent instructions (RAW, WAW).
- Sequences the register file's synchronous read by registering the accepted instruction's source addresses, then flags when the read data is valid.
- Sits between decode/issue and registerFile.
- The writeback unit drives the register file write port directly; this block only observes it.

Parameters:
MAX_PENDING, 4, maximum number of registers simultaneously marked busy (1..31)
CNT_W, 5, width of pending_count; must hold 31

Ports:
clk  in  1  rising-edge clock, the only clock
rst  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  combinational; instruction accepted when issue_valid && issue_ready
issue_rs1  in  5  source 1 address
issue_rs2  in  5  source 2 address
issue_uses_rs1  in  1  instruction reads rs1
issue_uses_rs2  in  1  instruction reads rs2
issue_rd  in  5  destination address
issue_rd_we  in  1  instruction writes rd
wb_valid  in  1  writeback this cycle; same signal drives RegWrite
wb_rd  in  5  writeback destination
flush  in  1  squash in-flight state (branch redirect)
rf_rs1  out  5  registered, to registerFile rs1
rf_rs2  out  5  registered, to registerFile rs2
rd_valid  out  1  registerFile data_1/data_2 valid this cycle for the issued instruction
rd_tag  out  5  rd of the instruction whose operands are valid
busy_mask  out  32  current busy bits, bit 0 always 0
pending_count  out  CNT_W  popcount of busy_mask
wb_err  out  1  sticky: writeback to a non-busy register seen

Behaviour:
- Reset (rst high at an edge): busy_mask=0, pending_count=0, rf_rs1=rf_rs2=0, rd_valid=0, rd_tag=0, wb_err=0, stage-1 valid=0. issue_ready is 0 while rst is high.
- src_hz(r, use) = use && r!=0 && busy[r] && !bypass(r).
  - bypass(r) = wb_valid && wb_rd==r when the optional feature is enabled.
  - bypass(r) = 0 otherwise.
- waw = issue_rd_we && issue_rd!=0 && busy[issue_rd]. No bypass applies to waw.
- full = pending_count >= MAX_PENDING && !(wb_valid && busy[wb_rd]).
- issue_ready = !rst && !flush && !src_hz(rs1) && !src_hz(rs2) && !waw && !full.
- On accept at edge E0:
  - rf_rs1<=issue_rs1, rf_rs2<=issue_rs2; stage-1 valid<=1; stage-1 tag<=issue_rd.
  - Sources not used drive address 0.
  - If issue_rd_we && issue_rd!=0, set busy[issue_rd].
- At E1, registerFile registers its data outputs; rd_valid<=stage-1 valid and rd_tag<=stage-1 tag. rd_valid is therefore high in the cycle after E1, aligned with data_1/data_2. Latency from accept to rd_valid is 2 edges.
- Back-to-back accepts are allowed every cycle; the pipeline never stalls internally.
- Without an accept at an edge: stage-1 valid<=0, rf_rs1/rf_rs2 hold their values.
- Writeback: at an edge with wb_valid && wb_rd!=0:
  - If busy[wb_rd], clear it.
  - If not busy, set wb_err (sticky until rst).
  - wb_rd==0 is ignored.
- Same-edge set and clear on different registers: pending_count <= pending_count + set - clear. A set and a clear on the same register cannot occur, because waw stalls it.
- flush high at an edge:
  - busy_mask<=0, pending_count<=0, stage-1 valid<=0, rd_valid<=0.
  - flush beats a simultaneous accept (issue_ready is already 0) and beats writeback.
  - wb_err is unaffected.
- rst beats flush.
- x0 is never busy, never stalls, and is never counted.

Optional Feature:
Macro SCOREBOARD_WB_BYPASS_EN.
- Defined: a writeback to rs in the same cycle as issue removes the source hazard. The write lands at E0 and the read happens at E1, so the read sees new data.
- Undefined: bypass(r)=0, so the dependent instruction stalls until busy clears; one extra cycle versus defined.
- waw and full behaviour are identical in both builds.

Test Plan:
- Reset, then issue (rs1=1, rs2=2, rd=3, we): issue_ready=1 in the same cycle; two edges later rd_valid=1 with rd_tag=3; busy_mask=0x8, pending_count=1.
- With x5 busy, issue rs1=5 -> issue_ready=0. wb_valid with wb_rd=5 in the same cycle -> ready=1 with the macro defined; without it, ready=0 that cycle and 1 the next; busy_mask bit 5 clears.
- With x7 busy, issue with rd=7, we=1 -> stalled until wb_rd=7. Issue with rd=0, we=1 -> never stalls and busy_mask is unchanged.
- Fill MAX_PENDING=4 (rd=1..4) -> pending_count=4 and a fifth write-issue is stalled. Same-cycle wb_rd=2 -> the fifth is accepted and pending_count stays 4.
- With 3 busy and an accept in flight, assert flush -> next cycle busy_mask=0, pending_count=0, rd_valid=0; an issue during flush is not accepted.
- wb_rd=9 with x9 not busy -> wb_err=1 and stays 1 through a flush; rst clears it.
